fcw_sweep_ctrl: RTL and testbench

- Generates a time-varying Frequency Control Word (FCW) that drives the phase-increment input of the NCO core.
- Turns the fixed-tone NCO path into a programmable chirp/sweep source for DA output and Gaussian-filter characterisation.
- Runs in the NCO clock domain (100 MHz PLL output). One FCW update at most per clock.

---
 rtl/fcw_sweep_ctrl_pkg.sv | 18 +
 rtl/fcw_sweep_ctrl_if.sv | 30 +++
 rtl/fcw_sweep_ctrl_dwell_timer.sv | 28 ++
 rtl/fcw_sweep_ctrl.sv | 158 +++++++++++++++
 tb/tb_fcw_sweep_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fcw_sweep_ctrl_pkg.sv
// Shared constants for the FCW sweep controller: sweep-mode codes, FSM states, default widths.
package fcw_sweep_ctrl_pkg;

  localparam int unsigned FcwWDefault   = 32;
  localparam int unsigned DwellWDefault = 16;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StStep
  } state_e;

endpackage

// File: rtl/fcw_sweep_ctrl_if.sv
// Control/status bundle between a sweep requester (master) and the sweep controller (slave).
interface fcw_sweep_ctrl_if
  import fcw_sweep_ctrl_pkg::*;
#(
  parameter int unsigned FCW_W   = FcwWDefault,
  parameter int unsigned DWELL_W = DwellWDefault
);
  logic               start;
  logic               abort;
  logic [1:0]         mode;
  logic [FCW_W-1:0]   fcw_start;
  logic [FCW_W-1:0]   fcw_stop;
  logic [FCW_W-1:0]   fcw_step;
  logic [DWELL_W-1:0] dwell;
  logic [FCW_W-1:0]   fcw_out;
  logic               fcw_valid;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output start, abort, mode, fcw_start, fcw_stop, fcw_step, dwell,
    input  fcw_out, fcw_valid, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, mode, fcw_start, fcw_stop, fcw_step, dwell,
    output fcw_out, fcw_valid, busy, done, cfg_err
  );
endinterface

// File: rtl/fcw_sweep_ctrl_dwell_timer.sv
// Loadable dwell down-counter; tc_o flags the last hold cycle of the current FCW value.
module fcw_sweep_ctrl_dwell_timer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               en_i,
  output logic               tc_o
);
  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/fcw_sweep_ctrl.sv
// Programmable FCW sweep source (single, sawtooth, triangle) feeding the NCO phase increment.
module fcw_sweep_ctrl
  import fcw_sweep_ctrl_pkg::*;
#(
  parameter int unsigned FCW_W   = FcwWDefault,
  parameter int unsigned DWELL_W = DwellWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  fcw_sweep_ctrl_if.slave   bus
);
  state_e             state_q, state_d;
  logic [FCW_W-1:0]   fcw_q, fcw_d;
  logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               dir_up_q, dir_up_d;
  logic [1:0]         mode_q, mode_d;
  logic [FCW_W-1:0]   start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_sel, tmr_val;
  logic               tmr_clr, tmr_load, tmr_en, tmr_tc;
  logic [FCW_W:0]     sum_w, diff_w;
  logic               up_oor, down_oor;

  // One extra bit catches carry-out / borrow so a sweep never wraps.
  assign sum_w    = {1'b0, fcw_q} + {1'b0, step_q};
  assign diff_w   = {1'b0, fcw_q} - {1'b0, step_q};
  assign up_oor   = sum_w[FCW_W] || (sum_w[FCW_W-1:0] > stop_q);
  assign down_oor = diff_w[FCW_W] || (diff_w[FCW_W-1:0] < start_q);

  // Timer holds dwell-1 after an issue; the final hold cycle is spent in StStep.
  assign dwell_sel = (state_q == StIdle) ? bus.dwell : dwell_q;
  assign tmr_val   = (dwell_sel == '0) ? '0 : dwell_sel - 1'b1;

  fcw_sweep_ctrl_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    fcw_d    = fcw_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    dir_up_d = dir_up_q;
    mode_d   = mode_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    if (bus.abort) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if ((bus.fcw_step == '0) || (bus.fcw_start > bus.fcw_stop) ||
                (bus.mode == MODE_RSVD)) begin
              err_d = 1'b1;
            end else begin
              mode_d   = bus.mode;
              start_d  = bus.fcw_start;
              stop_d   = bus.fcw_stop;
              step_d   = bus.fcw_step;
              dwell_d  = bus.dwell;
              fcw_d    = bus.fcw_start;
              valid_d  = 1'b1;
              busy_d   = 1'b1;
              dir_up_d = 1'b1;
              tmr_load = 1'b1;
              state_d  = (bus.dwell == '0) ? StStep : StHold;
            end
          end
        end
        StHold: begin
          if (tmr_tc) state_d = StStep;
          else        tmr_en  = 1'b1;
        end
        StStep: begin
          valid_d = 1'b1;
          if (!(dir_up_q ? up_oor : down_oor)) begin
            fcw_d = dir_up_q ? sum_w[FCW_W-1:0] : diff_w[FCW_W-1:0];
          end else begin
            unique case (mode_q)
              MODE_SINGLE: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
              end
              MODE_SAW: fcw_d = start_q;
              default: begin
                dir_up_d = ~dir_up_q;
                // Degenerate span: neither direction fits, so repeat the current value.
                if (dir_up_q) fcw_d = down_oor ? fcw_q : diff_w[FCW_W-1:0];
                else          fcw_d = up_oor   ? fcw_q : sum_w[FCW_W-1:0];
              end
            endcase
          end
          if (valid_d) begin
            tmr_load = 1'b1;
            state_d  = (dwell_q == '0) ? StStep : StHold;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      fcw_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dir_up_q <= 1'b1;
      mode_q   <= MODE_SINGLE;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      fcw_q    <= fcw_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dir_up_q <= dir_up_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
    end
  end

  assign bus.fcw_out   = fcw_q;
  assign bus.fcw_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_fcw_sweep_ctrl.sv
// Directed bench for fcw_sweep_ctrl: sweep modes, overflow, config errors, abort and reset.
module tb_fcw_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  fcw_sweep_ctrl_if bus ();

  fcw_sweep_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [31:0] s, input logic [31:0] e,
                         input logic [31:0] st, input logic [15:0] dw);
    bus.mode      = m;
    bus.fcw_start = s;
    bus.fcw_stop  = e;
    bus.fcw_step  = st;
    bus.dwell     = dw;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  logic [31:0] tri_seq [9];
  logic [31:0] exp_fcw;

  initial begin
    tri_seq = '{32'd0, 32'd10, 32'd20, 32'd30, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20};
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(2'd0, 32'd0, 32'd0, 32'd0, 16'd0);
    #12;
    chk_eq("rst_fcw", bus.fcw_out, 0);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_valid", bus.fcw_valid, 0);
    rst_n = 1'b1;
    tick();

    // Single up-sweep 100..130 step 10, dwell 2.
    set_cfg(2'd0, 32'd100, 32'd130, 32'd10, 16'd2);
    go();
    set_cfg(2'd1, 32'd7, 32'd9, 32'd1, 16'd0);
    for (int t = 0; t < 14; t++) begin
      exp_fcw = (t < 12) ? 32'(100 + 10 * (t / 3)) : 32'd130;
      chk_eq($sformatf("m0_fcw_t%0d", t), bus.fcw_out, exp_fcw);
      chk_eq($sformatf("m0_valid_t%0d", t), bus.fcw_valid, (t < 12) && (t % 3 == 0));
      chk_eq($sformatf("m0_done_t%0d", t), bus.done, t == 12);
      chk_eq($sformatf("m0_busy_t%0d", t), bus.busy, t < 12);
      tick();
    end

    // Sawtooth 100..125 step 10, dwell 0; a start while busy must be ignored; abort at cycle 5.
    set_cfg(2'd1, 32'd100, 32'd125, 32'd10, 16'd0);
    go();
    for (int t = 0; t < 5; t++) begin
      chk_eq($sformatf("m1_fcw_t%0d", t), bus.fcw_out, 32'(100 + 10 * (t % 3)));
      chk_eq($sformatf("m1_valid_t%0d", t), bus.fcw_valid, 1);
      chk_eq($sformatf("m1_busy_t%0d", t), bus.busy, 1);
      chk_eq($sformatf("m1_done_t%0d", t), bus.done, 0);
      if (t == 1) begin
        set_cfg(2'd0, 32'd5, 32'd6, 32'd1, 16'd3);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      bus.abort = (t == 4);
      tick();
    end
    bus.abort = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk_eq($sformatf("ab_fcw_t%0d", t), bus.fcw_out, 32'd110);
      chk_eq($sformatf("ab_busy_t%0d", t), bus.busy, 0);
      chk_eq($sformatf("ab_done_t%0d", t), bus.done, 0);
      chk_eq($sformatf("ab_valid_t%0d", t), bus.fcw_valid, 0);
      tick();
    end

    // Triangle 0..30 step 10, dwell 1: turning values held once.
    set_cfg(2'd2, 32'd0, 32'd30, 32'd10, 16'd1);
    go();
    for (int t = 0; t < 18; t++) begin
      chk_eq($sformatf("m2_fcw_t%0d", t), bus.fcw_out, tri_seq[t / 2]);
      chk_eq($sformatf("m2_valid_t%0d", t), bus.fcw_valid, t % 2 == 0);
      tick();
    end
    do_abort();
    chk_eq("m2_abort_busy", bus.busy, 0);

    // Carry-out near the top of the FCW range ends the sweep without wrapping.
    set_cfg(2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0);
    go();
    chk_eq("ovf_fcw0", bus.fcw_out, 32'hFFFF_FFF0);
    chk_eq("ovf_valid0", bus.fcw_valid, 1);
    tick();
    chk_eq("ovf_done", bus.done, 1);
    chk_eq("ovf_valid1", bus.fcw_valid, 0);
    chk_eq("ovf_busy", bus.busy, 0);
    chk_eq("ovf_fcw1", bus.fcw_out, 32'hFFFF_FFF0);
    tick();

    // Rejected configurations.
    set_cfg(2'd0, 32'd10, 32'd20, 32'd0, 16'd0);
    go();
    chk_eq("err_step0", bus.cfg_err, 1);
    chk_eq("err_step0_busy", bus.busy, 0);
    chk_eq("err_step0_fcw", bus.fcw_out, 32'hFFFF_FFF0);
    tick();
    chk_eq("err_pulse_end", bus.cfg_err, 0);
    set_cfg(2'd0, 32'd50, 32'd40, 32'd1, 16'd0);
    go();
    chk_eq("err_order", bus.cfg_err, 1);
    set_cfg(2'd3, 32'd10, 32'd20, 32'd1, 16'd0);
    go();
    chk_eq("err_mode3", bus.cfg_err, 1);
    chk_eq("err_mode3_valid", bus.fcw_valid, 0);
    set_cfg(2'd0, 32'd50, 32'd40, 32'd1, 16'd0);
    bus.abort = 1'b1;
    go();
    bus.abort = 1'b0;
    chk_eq("abort_start_err", bus.cfg_err, 0);
    chk_eq("abort_start_busy", bus.busy, 0);

    // Sawtooth with start==stop re-issues the single value every dwell+1 cycles.
    set_cfg(2'd1, 32'd77, 32'd77, 32'd5, 16'd1);
    go();
    for (int t = 0; t < 6; t++) begin
      chk_eq($sformatf("eq_fcw_t%0d", t), bus.fcw_out, 32'd77);
      chk_eq($sformatf("eq_valid_t%0d", t), bus.fcw_valid, t % 2 == 0);
      tick();
    end

    // Asynchronous reset mid-hold, then a fresh sweep.
    rst_n = 1'b0;
    #1;
    chk_eq("arst_fcw", bus.fcw_out, 0);
    chk_eq("arst_busy", bus.busy, 0);
    chk_eq("arst_valid", bus.fcw_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    set_cfg(2'd0, 32'd3, 32'd3, 32'd1, 16'd0);
    go();
    chk_eq("post_fcw", bus.fcw_out, 32'd3);
    chk_eq("post_valid", bus.fcw_valid, 1);
    chk_eq("post_busy", bus.busy, 1);
    tick();
    chk_eq("post_done", bus.done, 1);
    chk_eq("post_busy_low", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
